vc_sync_fifo: RTL and testbench

- Parametrised single-clock, multi-channel FIFO used as the router input buffer.
- Holds NUM_VC independent virtual-channel queues, each 2^ADDRSIZE entries deep.
- Reads are first-word-fall-through: the head of the selected VC is always visible.
- Adds per-VC almost-full flags, credit return to the upstream link, and sticky overflow/underflow error flags.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/vc_fifo_ctrl.sv | 90 +++++++++
 rtl/vc_sync_fifo.sv | 117 +++++++++++
 tb/tb_vc_sync_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared NoC types: default flit width, flit type, VC index width
//            helper and the credit-return record.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Default flit width used by the router input buffers
  localparam int DSIZE_DEF = 32;

  // Widest VC index a credit record can carry
  localparam int CREDIT_VCW_MAX = 8;

  typedef logic [DSIZE_DEF-1:0] flit_t;

  // Credit returned upstream for each flit popped from a VC queue
  typedef struct packed {
    logic                      valid;
    logic [CREDIT_VCW_MAX-1:0] vc;
  } credit_t;

  // Index width for n virtual channels (never below one bit)
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/vc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_ctrl
// Brief    : Per-VC queue bookkeeping: read/write pointers, occupancy count,
//            full/empty/almost-full flags and sticky overflow/underflow bits.
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo_ctrl #(
  parameter int ADDRSIZE  = 2,
  parameter int AFULL_LVL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc_i,     // write request aimed at this VC
  input  logic                rinc_i,     // read request aimed at this VC
  input  logic                err_clr_i,
  output logic                wr_ok_o,    // write accepted this cycle
  output logic                rd_ok_o,    // read accepted this cycle
  output logic [ADDRSIZE-1:0] wptr_o,
  output logic [ADDRSIZE-1:0] rptr_o,
  output logic [ADDRSIZE:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                afull_o,
  output logic                ovf_o,
  output logic                udf_o
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE+1)'(DEPTH);
  // Threshold clamps at zero so an oversized AFULL_LVL keeps the flag high
  localparam int AF_TH_I = (DEPTH > AFULL_LVL) ? (DEPTH - AFULL_LVL) : 0;
  localparam logic [ADDRSIZE:0] AF_TH_C = (ADDRSIZE+1)'(AF_TH_I);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                rd_ok, wr_ok;

  // Acceptance and next-state: a full VC still takes a write when a
  // same-VC read frees a slot in the same cycle (pass-through)
  always_comb begin
    rd_ok   = rinc_i & ~empty_o;
    wr_ok   = winc_i & (~full_o | rd_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + ADDRSIZE'(1);
    if (rd_ok) rptr_d = rptr_q + ADDRSIZE'(1);
    if (wr_ok && !rd_ok)      count_d = count_q + (ADDRSIZE+1)'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - (ADDRSIZE+1)'(1);
    // Clear first, then a fresh error in the same cycle re-sets the bit
    ovf_d = (ovf_q & ~err_clr_i) | (winc_i & ~wr_ok);
    udf_d = (udf_q & ~err_clr_i) | (rinc_i & empty_o);
  end

  // Pointer, count and sticky-error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Status flags derive only from the registered count
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign afull_o = (count_q >= AF_TH_C);

  assign wr_ok_o = wr_ok;
  assign rd_ok_o = rd_ok;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule : vc_fifo_ctrl
`default_nettype wire

// File: rtl/vc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vc_sync_fifo
// Brief    : Single-clock multi-VC FWFT input buffer with shared flat
//            storage, per-VC flags, credit return and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module vc_sync_fifo
  import noc_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ADDRSIZE  = 2,
  parameter int NUM_VC    = 4,
  parameter int AFULL_LVL = 1,
  localparam int VCW      = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [VCW-1:0]    wvc,
  input  logic [DSIZE-1:0]  wdata,
  output logic [NUM_VC-1:0] wfull,
  output logic [NUM_VC-1:0] wafull,
  input  logic              rinc,
  input  logic [VCW-1:0]    rvc,
  output logic [DSIZE-1:0]  rdata,
  output logic [NUM_VC-1:0] rempty,
  output logic [ADDRSIZE:0] rcount,
  output logic              credit_valid,
  output logic [VCW-1:0]    credit_vc,
  output logic [NUM_VC-1:0] ovf_err,
  output logic [NUM_VC-1:0] udf_err,
  input  logic              err_clr
);

  localparam int DEPTH   = 1 << ADDRSIZE;
  localparam int ENTRIES = NUM_VC * DEPTH;

  logic [ADDRSIZE-1:0] wptr_w  [NUM_VC];
  logic [ADDRSIZE-1:0] rptr_w  [NUM_VC];
  logic [ADDRSIZE:0]   count_w [NUM_VC];
  logic [NUM_VC-1:0]   wr_ok_w;
  logic [NUM_VC-1:0]   rd_ok_w;
  logic                wr_any;
  logic                rd_any;
  logic [VCW+ADDRSIZE-1:0] waddr;
  logic [VCW+ADDRSIZE-1:0] raddr;

  logic [DSIZE-1:0] mem_q [ENTRIES];
  credit_t          credit_q, credit_d;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo_ctrl #(
      .ADDRSIZE  (ADDRSIZE),
      .AFULL_LVL (AFULL_LVL)
    ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .winc_i    (winc && (wvc == VCW'(g))),
      .rinc_i    (rinc && (rvc == VCW'(g))),
      .err_clr_i (err_clr),
      .wr_ok_o   (wr_ok_w[g]),
      .rd_ok_o   (rd_ok_w[g]),
      .wptr_o    (wptr_w[g]),
      .rptr_o    (rptr_w[g]),
      .count_o   (count_w[g]),
      .full_o    (wfull[g]),
      .empty_o   (rempty[g]),
      .afull_o   (wafull[g]),
      .ovf_o     (ovf_err[g]),
      .udf_o     (udf_err[g])
    );
  end

  // Only the addressed VC can accept, so OR-reduction gives the port enables
  assign wr_any = |wr_ok_w;
  assign rd_any = |rd_ok_w;
  assign waddr  = {wvc, wptr_w[wvc]};
  assign raddr  = {rvc, rptr_w[rvc]};

  // Shared storage write port; contents are left untouched by reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_any) begin
      mem_q[waddr] <= wdata;
    end
  end

  // FWFT read port: head of the selected VC is always on rdata
  assign rdata  = mem_q[raddr];
  assign rcount = count_w[rvc];

  // Credit record: pulse for every accepted read, VC held between pulses
  always_comb begin
    credit_d.valid = rd_any;
    credit_d.vc    = rd_any ? CREDIT_VCW_MAX'(rvc) : credit_q.vc;
  end

  // Registered credit output, one cycle after the accepted read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_valid = credit_q.valid;
  assign credit_vc    = credit_q.vc[VCW-1:0];

  // Upper credit VC bits are always zero for this channel count
  if (VCW < CREDIT_VCW_MAX) begin : g_credit_pad
    logic unused_credit_pad;
    assign unused_credit_pad = ^credit_q.vc[CREDIT_VCW_MAX-1:VCW];
  end

endmodule : vc_sync_fifo
`default_nettype wire

// File: tb/tb_vc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_sync_fifo
// Brief    : Self-checking bench for vc_sync_fifo: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_sync_fifo;
  import noc_pkg::*;

  localparam int DSIZE     = 32;
  localparam int ADDRSIZE  = 2;
  localparam int NUM_VC    = 4;
  localparam int AFULL_LVL = 1;
  localparam int VCW       = 2;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              winc;
  logic [VCW-1:0]    wvc;
  logic [DSIZE-1:0]  wdata;
  logic [NUM_VC-1:0] wfull;
  logic [NUM_VC-1:0] wafull;
  logic              rinc;
  logic [VCW-1:0]    rvc;
  logic [DSIZE-1:0]  rdata;
  logic [NUM_VC-1:0] rempty;
  logic [ADDRSIZE:0] rcount;
  logic              credit_valid;
  logic [VCW-1:0]    credit_vc;
  logic [NUM_VC-1:0] ovf_err;
  logic [NUM_VC-1:0] udf_err;
  logic              err_clr;

  vc_sync_fifo #(
    .DSIZE     (DSIZE),
    .ADDRSIZE  (ADDRSIZE),
    .NUM_VC    (NUM_VC),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wvc          (wvc),
    .wdata        (wdata),
    .wfull        (wfull),
    .wafull       (wafull),
    .rinc         (rinc),
    .rvc          (rvc),
    .rdata        (rdata),
    .rempty       (rempty),
    .rcount       (rcount),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd_acc = 0;
  int n_cred = 0;

  // Reference model: one plain queue per VC plus sticky error / credit state
  flit_t             mq [NUM_VC][$];
  logic [NUM_VC-1:0] m_ovf;
  logic [NUM_VC-1:0] m_udf;
  logic              m_cv;
  logic [VCW-1:0]    m_cvc;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output with the model (called mid-cycle)
  task automatic check_all();
    logic [NUM_VC-1:0] e_empty, e_full, e_afull;
    for (int v = 0; v < NUM_VC; v++) begin
      e_empty[v] = (mq[v].size() == 0);
      e_full[v]  = (mq[v].size() == DEPTH);
      e_afull[v] = (mq[v].size() >= DEPTH - AFULL_LVL);
    end
    chk_eq("rempty", rempty, e_empty);
    chk_eq("wfull",  wfull,  e_full);
    chk_eq("wafull", wafull, e_afull);
    chk_eq("rcount", rcount, mq[rvc].size());
    if (mq[rvc].size() > 0) chk_eq("rdata", rdata, mq[rvc][0]);
    chk_eq("credit_valid", credit_valid, m_cv);
    if (m_cv) chk_eq("credit_vc", credit_vc, m_cvc);
    chk_eq("ovf_err", ovf_err, m_ovf);
    chk_eq("udf_err", udf_err, m_udf);
    if (credit_valid === 1'b1) n_cred++;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge
  task automatic cycle(input logic r, input logic w, input logic [VCW-1:0] wv,
                       input logic [DSIZE-1:0] wd, input logic rd,
                       input logic [VCW-1:0] rv, input logic clr);
    logic rok, wok;
    rst_n = r; winc = w; wvc = wv; wdata = wd; rinc = rd; rvc = rv; err_clr = clr;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!r) begin
      for (int v = 0; v < NUM_VC; v++) mq[v].delete();
      m_ovf = '0; m_udf = '0; m_cv = 1'b0; m_cvc = '0;
    end else begin
      rok = rd && (mq[rv].size() > 0);
      wok = w && ((mq[wv].size() < DEPTH) || (rok && (rv == wv)));
      if (clr) begin m_ovf = '0; m_udf = '0; end
      if (w && !wok) m_ovf[wv] = 1'b1;
      if (rd && !rok) m_udf[rv] = 1'b1;
      if (rok) begin void'(mq[rv].pop_front()); n_rd_acc++; end
      if (wok) mq[wv].push_back(wd);
      m_cv = rok;
      if (rok) m_cvc = rv;
    end
    #1;
  endtask

  task automatic wr(input logic [VCW-1:0] v, input logic [DSIZE-1:0] d, input logic [VCW-1:0] rv);
    cycle(1'b1, 1'b1, v, d, 1'b0, rv, 1'b0);
  endtask

  task automatic rd(input logic [VCW-1:0] v);
    cycle(1'b1, 1'b0, '0, '0, 1'b1, v, 1'b0);
  endtask

  initial begin
    logic [VCW-1:0] tv;
    rst_n = 1'b0; winc = 1'b0; wvc = '0; wdata = '0; rinc = 1'b0; rvc = '0; err_clr = 1'b0;
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_ovf = '0; m_udf = '0; m_cv = 1'b0; m_cvc = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_eq("rst_rempty", rempty, 4'hF);
    chk_eq("rst_credit_vc", credit_vc, 0);

    // Single flit through VC2
    wr(2'd2, 32'h0000BBBB, 2'd0);
    rvc = 2'd2; #1;
    chk_eq("t1_rempty", rempty, 4'b1011);
    chk_eq("t1_rdata", rdata, 32'h0000BBBB);
    chk_eq("t1_rcount", rcount, 1);
    rd(2'd2);
    chk_eq("t1_cv", credit_valid, 1'b1);
    chk_eq("t1_cvc", credit_vc, 2'd2);
    chk_eq("t1_empty2", rempty[2], 1'b1);

    // Fill VC0, overflow, drain in order
    for (int i = 1; i <= 5; i++) begin
      wr(2'd0, DSIZE'(i), 2'd0);
      if (i == 3) begin
        chk_eq("t2_afull3", wafull[0], 1'b1);
        chk_eq("t2_full3", wfull[0], 1'b0);
      end
      if (i == 4) chk_eq("t2_full4", wfull[0], 1'b1);
    end
    chk_eq("t2_ovf", ovf_err[0], 1'b1);
    chk_eq("t2_rcount", rcount, 4);
    for (int i = 1; i <= 4; i++) begin
      chk_eq("t2_order", rdata, DSIZE'(i));
      rd(2'd0);
    end

    // Pass-through on a full VC1 with pointer wrap
    for (int i = 0; i < 4; i++) wr(2'd1, DSIZE'(32'h10 + i), 2'd1);
    cycle(1'b1, 1'b1, 2'd1, 32'h0000CCCC, 1'b1, 2'd1, 1'b0);
    chk_eq("t3_rcount", rcount, 4);
    chk_eq("t3_ovf1", ovf_err[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk_eq("t3_last", rdata, 32'h0000CCCC);
      rd(2'd1);
    end

    // Read of empty VC3 with a same-cycle write: no bypass
    cycle(1'b1, 1'b1, 2'd3, 32'h0000DDDD, 1'b1, 2'd3, 1'b0);
    chk_eq("t4_udf", udf_err[3], 1'b1);
    chk_eq("t4_nocredit", credit_valid, 1'b0);
    chk_eq("t4_rdata", rdata, 32'h0000DDDD);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 2'd3, 1'b1);
    chk_eq("t4_udf_clr", udf_err, 4'h0);
    chk_eq("t4_ovf_clr", ovf_err, 4'h0);
    rd(2'd3);

    // Interleaved traffic: writes to VC0/1, reads of VC2/3
    for (int i = 0; i < 3; i++) begin
      wr(2'd2, $urandom, 2'd2);
      wr(2'd3, $urandom, 2'd3);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    n_cred = 0; n_rd_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 3) != 0), 2'($urandom_range(2, 3)), 1'b0);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    chk_eq("t5_credits", n_cred, n_rd_acc);

    // Mid-operation reset discards queued flits without credits
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) wr(2'd0, DSIZE'(32'h50 + i), 2'd0);
    chk_eq("t6_pre_cnt", rcount, 3);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    chk_eq("t6_rempty", rempty, 4'hF);
    chk_eq("t6_cv", credit_valid, 1'b0);
    chk_eq("t6_cvc", credit_vc, 2'd0);
    chk_eq("t6_rcount", rcount, 0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);
    chk_eq("t6_cv_idle", credit_valid, 1'b0);
    wr(2'd0, 32'h000000A1, 2'd0);
    wr(2'd0, 32'h000000A2, 2'd0);
    chk_eq("t6_rd1", rdata, 32'h000000A1);
    rd(2'd0);
    chk_eq("t6_rd2", rdata, 32'h000000A2);
    rd(2'd0);

    // Long randomized run across all VCs, with error clears and resets
    for (int i = 0; i < 400; i++) begin
      tv = 2'($urandom_range(0, NUM_VC - 1));
      cycle(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 9) < 6), tv, $urandom,
            1'($urandom_range(0, 1)), 2'($urandom_range(0, NUM_VC - 1)),
            1'($urandom_range(0, 19) == 0));
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vc_sync_fifo
`default_nettype wire
